// File: rtl/if_fetch_controller.sv
// Fetch-stage sequencer: owns the PC and steers the IF/ID write-enable and flush controls.
// Arbitrates between branch redirects, load-use stalls, halt requests and instruction-memory wait states.
module if_fetch_controller #(
  parameter int PC_W         = 8,
  parameter int REG_AW       = 5,
  parameter int RESET_PC     = 0,
  parameter int WAIT_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              imem_ready,
  input  logic              branch_taken,
  input  logic [PC_W-1:0]   branch_target,
  input  logic              id_ex_mem_read,
  input  logic [REG_AW-1:0] id_ex_rd,
  input  logic [REG_AW-1:0] if_id_rs1,
  input  logic [REG_AW-1:0] if_id_rs2,
  input  logic              halt_req,
  input  logic              resume,
  output logic [PC_W-1:0]   pc,
  output logic              ifid_write_en,
  output logic              ifid_flush,
  output logic              idex_bubble,
  output logic              halted,
  output logic              fetch_err,
  output logic [15:0]       stall_cycles
);

  localparam int WCNT_W = $clog2(WAIT_TIMEOUT + 1);

  typedef enum logic [1:0] {FETCH, MEM_WAIT, HALT} state_t;

  state_t              state_q, state_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic [WCNT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic                fetch_err_q, fetch_err_d;
  logic [15:0]         stall_q, stall_d;
  logic                load_use;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign load_use = id_ex_mem_read && (id_ex_rd != '0) &&
                    ((id_ex_rd == if_id_rs1) || (id_ex_rd == if_id_rs2));

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    wait_cnt_d    = wait_cnt_q;
    fetch_err_d   = fetch_err_q;
    ifid_write_en = 1'b0;
    ifid_flush    = 1'b0;
    idex_bubble   = 1'b0;
    if (rst) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else begin
      case (state_q)
        HALT: begin
          ifid_flush = 1'b1;
          // A timed-out fetch stays parked until reset.
          if (resume && !fetch_err_q) state_d = FETCH;
        end
        default: begin
          if (branch_taken) begin
            pc_d        = branch_target;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            state_d     = FETCH;
            wait_cnt_d  = '0;
          end else if (load_use) begin
            idex_bubble = 1'b1;
          end else if (halt_req) begin
            ifid_flush = 1'b1;
            state_d    = HALT;
            wait_cnt_d = '0;
          end else if (!imem_ready) begin
            ifid_flush = 1'b1;
            if (wait_cnt_q == WCNT_W'(WAIT_TIMEOUT - 1)) begin
              fetch_err_d = 1'b1;
              state_d     = HALT;
              wait_cnt_d  = '0;
            end else begin
              state_d    = MEM_WAIT;
              wait_cnt_d = wait_cnt_q + 1'b1;
            end
          end else begin
            ifid_write_en = 1'b1;
            pc_d          = pc_q + 1'b1;
            state_d       = FETCH;
            wait_cnt_d    = '0;
          end
        end
      endcase
    end
    stall_d = (!rst && !ifid_write_en && state_q != HALT) ? sat_inc(stall_q) : stall_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= FETCH;
      pc_q        <= PC_W'(RESET_PC);
      wait_cnt_q  <= '0;
      fetch_err_q <= 1'b0;
      stall_q     <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      wait_cnt_q  <= wait_cnt_d;
      fetch_err_q <= fetch_err_d;
      stall_q     <= stall_d;
    end
  end

  assign pc           = pc_q;
  assign halted       = (state_q == HALT);
  assign fetch_err    = fetch_err_q;
  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_if_fetch_controller.sv
// Directed bench for if_fetch_controller with hand-computed expectations.
module tb_if_fetch_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       imem_ready;
  logic       branch_taken;
  logic [7:0] branch_target;
  logic       id_ex_mem_read;
  logic [4:0] id_ex_rd;
  logic [4:0] if_id_rs1;
  logic [4:0] if_id_rs2;
  logic       halt_req;
  logic       resume;
  logic [7:0] pc;
  logic       ifid_write_en;
  logic       ifid_flush;
  logic       idex_bubble;
  logic       halted;
  logic       fetch_err;
  logic [15:0] stall_cycles;

  int n_cmp = 0;
  int n_bad = 0;

  if_fetch_controller dut (
    .clk(clk), .rst(rst), .imem_ready(imem_ready),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .id_ex_mem_read(id_ex_mem_read), .id_ex_rd(id_ex_rd),
    .if_id_rs1(if_id_rs1), .if_id_rs2(if_id_rs2),
    .halt_req(halt_req), .resume(resume), .pc(pc),
    .ifid_write_en(ifid_write_en), .ifid_flush(ifid_flush),
    .idex_bubble(idex_bubble), .halted(halted),
    .fetch_err(fetch_err), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; imem_ready = 1'b1; branch_taken = 1'b0; branch_target = 8'h00;
    id_ex_mem_read = 1'b0; id_ex_rd = 5'd0; if_id_rs1 = 5'd0; if_id_rs2 = 5'd0;
    halt_req = 1'b0; resume = 1'b0;
    tick();
    tick();
    chk("rst_we", 32'(ifid_write_en), 0);
    chk("rst_flush", 32'(ifid_flush), 1);
    chk("rst_bubble", 32'(idex_bubble), 1);
    chk("rst_pc", 32'(pc), 0);
    chk("rst_halted", 32'(halted), 0);
    chk("rst_err", 32'(fetch_err), 0);
    chk("rst_stall", 32'(stall_cycles), 0);

    // Sequential fetch
    rst = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) begin
      chk("seq_pc", 32'(pc), 32'(i));
      chk("seq_we", 32'(ifid_write_en), 1);
      tick();
    end
    chk("seq_pc5", 32'(pc), 5);
    chk("seq_stall", 32'(stall_cycles), 0);

    // Wrap from FF
    branch_taken = 1'b1; branch_target = 8'hFF;
    tick();
    branch_taken = 1'b0;
    chk("wrap_pre", 32'(pc), 32'hFF);
    tick();
    chk("wrap_pc", 32'(pc), 0);
    chk("wrap_err", 32'(fetch_err), 0);
    chk("wrap_stall", 32'(stall_cycles), 1);

    // Load-use at pc=10
    branch_taken = 1'b1; branch_target = 8'd10;
    tick();
    branch_taken = 1'b0;
    id_ex_mem_read = 1'b1; id_ex_rd = 5'd3; if_id_rs2 = 5'd3;
    #1;
    chk("lu_we", 32'(ifid_write_en), 0);
    chk("lu_flush", 32'(ifid_flush), 0);
    chk("lu_bubble", 32'(idex_bubble), 1);
    tick();
    chk("lu_pc_hold", 32'(pc), 10);
    id_ex_mem_read = 1'b0;
    tick();
    chk("lu_pc_next", 32'(pc), 11);
    chk("lu_stall", 32'(stall_cycles), 3);
    id_ex_mem_read = 1'b1; id_ex_rd = 5'd0; if_id_rs1 = 5'd0; if_id_rs2 = 5'd0;
    #1;
    chk("lu0_we", 32'(ifid_write_en), 1);
    chk("lu0_bubble", 32'(idex_bubble), 0);
    tick();
    chk("lu0_pc", 32'(pc), 12);
    chk("lu0_stall", 32'(stall_cycles), 3);

    // Branch beats load-use and memory wait
    branch_taken = 1'b1; branch_target = 8'h40;
    id_ex_rd = 5'd3; if_id_rs1 = 5'd3; imem_ready = 1'b0;
    #1;
    chk("br_we", 32'(ifid_write_en), 0);
    chk("br_flush", 32'(ifid_flush), 1);
    chk("br_bubble", 32'(idex_bubble), 1);
    tick();
    chk("br_pc", 32'(pc), 32'h40);
    chk("br_halted", 32'(halted), 0);
    branch_taken = 1'b0; id_ex_mem_read = 1'b0; imem_ready = 1'b1;
    #1;
    chk("br_fetch_we", 32'(ifid_write_en), 1);
    tick();
    chk("br_pc_inc", 32'(pc), 32'h41);
    chk("br_stall", 32'(stall_cycles), 4);

    // Short memory wait
    imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("mw_flush", 32'(ifid_flush), 1);
      chk("mw_we", 32'(ifid_write_en), 0);
      tick();
      chk("mw_pc", 32'(pc), 32'h41);
    end
    imem_ready = 1'b1;
    #1;
    chk("mw_cap_we", 32'(ifid_write_en), 1);
    tick();
    chk("mw_pc_inc", 32'(pc), 32'h42);
    chk("mw_stall", 32'(stall_cycles), 7);

    // Timeout after 15 wait cycles
    imem_ready = 1'b0;
    for (int i = 0; i < 14; i++) tick();
    chk("to_halted14", 32'(halted), 0);
    chk("to_err14", 32'(fetch_err), 0);
    tick();
    chk("to_err", 32'(fetch_err), 1);
    chk("to_halted", 32'(halted), 1);
    chk("to_stall", 32'(stall_cycles), 22);
    chk("halt_bubble", 32'(idex_bubble), 0);
    chk("halt_flush", 32'(ifid_flush), 1);
    resume = 1'b1; imem_ready = 1'b1;
    tick();
    tick();
    chk("to_resume_ign", 32'(halted), 1);
    chk("to_pc", 32'(pc), 32'h42);
    chk("to_stall_halt", 32'(stall_cycles), 22);
    resume = 1'b0; rst = 1'b1;
    tick();
    chk("to_rst_err", 32'(fetch_err), 0);
    chk("to_rst_halted", 32'(halted), 0);
    chk("to_rst_pc", 32'(pc), 0);
    rst = 1'b0;

    // Halt at pc=7
    for (int i = 0; i < 7; i++) tick();
    chk("h_pc7", 32'(pc), 7);
    halt_req = 1'b1;
    #1;
    chk("h_we", 32'(ifid_write_en), 0);
    chk("h_flush", 32'(ifid_flush), 1);
    tick();
    chk("h_halted", 32'(halted), 1);
    chk("h_pc", 32'(pc), 7);
    chk("h_stall", 32'(stall_cycles), 1);
    halt_req = 1'b0; branch_taken = 1'b1; branch_target = 8'h55;
    #1;
    chk("h_br_we", 32'(ifid_write_en), 0);
    tick();
    chk("h_br_pc", 32'(pc), 7);
    chk("h_br_halted", 32'(halted), 1);
    branch_taken = 1'b0; resume = 1'b1;
    tick();
    chk("h_res_halted", 32'(halted), 0);
    chk("h_res_pc", 32'(pc), 7);
    resume = 1'b0;
    #1;
    chk("h_res_we", 32'(ifid_write_en), 1);
    tick();
    chk("h_res_pc8", 32'(pc), 8);
    chk("h_res_stall", 32'(stall_cycles), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
